// File: rtl/state_register_ctrl.sv
// rtl/state_register_ctrl.sv - ASCON 320-bit state register with key XOR and cipher/tag output buffers
// Optional scrub input enabled by macro STATE_REG_SCRUB_EN.
// State layout on state_i/state_o: S0=[319:256], S1=[255:192], S2=[191:128], S3=[127:64], S4=[63:0].
module state_register_ctrl #(
  parameter int KEY_W  = 128,
  parameter int RATE_W = 128
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  input  logic              en_reg_state_i,
  input  logic [319:0]      state_i,
  input  logic              en_xor_key_end_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic              en_cipher_i,
  input  logic              en_tag_i,
`ifdef STATE_REG_SCRUB_EN
  input  logic              scrub_i,
`endif
  output logic [319:0]      state_o,
  output logic [RATE_W-1:0] cipher_o,
  output logic              cipher_valid_o,
  input  logic              cipher_ready_i,
  output logic [KEY_W-1:0]  tag_o,
  output logic              tag_valid_o,
  input  logic              tag_ready_i,
  output logic              stall_o,
  output logic              overflow_o
);

  typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_state_t;

  logic [63:0]       w_s0, w_s1, w_s2, w_s3, w_s4;
  logic [63:0]       w_s3_x, w_s4_x;
  logic              w_scrub;
  logic              w_cap;
  logic              w_cipher_load;
  logic              w_tag_load;
  logic              w_cipher_ovf;
  logic              w_tag_ovf;

  logic [319:0]      r_state;
  logic [RATE_W-1:0] r_cipher;
  logic [KEY_W-1:0]  r_tag;
  buf_state_t        r_cipher_st;
  buf_state_t        r_tag_st;
  logic              r_overflow;

  assign w_s0 = state_i[319:256];
  assign w_s1 = state_i[255:192];
  assign w_s2 = state_i[191:128];
  assign w_s3 = state_i[127:64];
  assign w_s4 = state_i[63:0];

  // Key is folded into the capacity words only; the rate words pass through untouched
  assign w_s3_x = en_xor_key_end_i ? (w_s3 ^ key_i[KEY_W-1 -: 64]) : w_s3;
  assign w_s4_x = en_xor_key_end_i ? (w_s4 ^ key_i[63:0])          : w_s4;

`ifdef STATE_REG_SCRUB_EN
  assign w_scrub = scrub_i;
`else
  assign w_scrub = 1'b0;
`endif

  // Scrub blocks every capture and load in the same cycle
  assign w_cap         = en_reg_state_i & ~w_scrub;
  assign w_cipher_load = w_cap & en_cipher_i;
  assign w_tag_load    = w_cap & en_tag_i;

  // Overwrite of an unaccepted value; a concurrent ready means the old value was taken
  assign w_cipher_ovf = (r_cipher_st == BUF_FULL) & w_cipher_load & ~cipher_ready_i;
  assign w_tag_ovf    = (r_tag_st == BUF_FULL) & w_tag_load & ~tag_ready_i;

  // Internal state register: capture permutation output with optional end-of-phase key XOR
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state <= '0;
    end else if (w_scrub) begin
      r_state <= '0;
    end else if (w_cap) begin
      r_state <= {w_s0, w_s1, w_s2, w_s3_x, w_s4_x};
    end
  end

  // Cipher buffer FSM: holds the pre-XOR rate words until downstream accepts them
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_cipher_st <= BUF_EMPTY;
      r_cipher    <= '0;
    end else if (w_scrub) begin
      r_cipher_st <= BUF_EMPTY;
      r_cipher    <= '0;
    end else begin
      case (r_cipher_st)
        BUF_EMPTY: begin
          if (w_cipher_load) begin
            r_cipher_st <= BUF_FULL;
            r_cipher    <= {w_s0, w_s1};
          end
        end
        BUF_FULL: begin
          if (w_cipher_load) begin
            r_cipher <= {w_s0, w_s1};
          end else if (cipher_ready_i) begin
            r_cipher_st <= BUF_EMPTY;
          end
        end
        default: r_cipher_st <= BUF_EMPTY;
      endcase
    end
  end

  // Tag buffer FSM: holds the post-XOR capacity words until downstream accepts them
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_tag_st <= BUF_EMPTY;
      r_tag    <= '0;
    end else if (w_scrub) begin
      r_tag_st <= BUF_EMPTY;
      r_tag    <= '0;
    end else begin
      case (r_tag_st)
        BUF_EMPTY: begin
          if (w_tag_load) begin
            r_tag_st <= BUF_FULL;
            r_tag    <= {w_s3_x, w_s4_x};
          end
        end
        BUF_FULL: begin
          if (w_tag_load) begin
            r_tag <= {w_s3_x, w_s4_x};
          end else if (tag_ready_i) begin
            r_tag_st <= BUF_EMPTY;
          end
        end
        default: r_tag_st <= BUF_EMPTY;
      endcase
    end
  end

  // Sticky overflow flag, survives scrub and clears only on reset
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_overflow <= 1'b0;
    end else if (w_cipher_ovf || w_tag_ovf) begin
      r_overflow <= 1'b1;
    end
  end

  assign state_o        = r_state;
  assign cipher_o       = r_cipher;
  assign tag_o          = r_tag;
  assign cipher_valid_o = (r_cipher_st == BUF_FULL);
  assign tag_valid_o    = (r_tag_st == BUF_FULL);
  assign overflow_o     = r_overflow;
  assign stall_o        = cipher_valid_o & ~cipher_ready_i;

endmodule

// File: tb/tb_state_register_ctrl.sv
// tb/tb_state_register_ctrl.sv - directed self-checking bench for state_register_ctrl
`timescale 1ns/1ps
module tb_state_register_ctrl;

  logic         clk;
  logic         resetb;
  logic         en_reg;
  logic [319:0] state_in;
  logic         en_xor;
  logic [127:0] key;
  logic         en_cipher;
  logic         en_tag;
  logic         scrub;
  logic [319:0] state_out;
  logic [127:0] cipher;
  logic         cipher_valid;
  logic         cipher_ready;
  logic [127:0] tag;
  logic         tag_valid;
  logic         tag_ready;
  logic         stall;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  state_register_ctrl #(.KEY_W(128), .RATE_W(128)) dut (
    .clock_i          (clk),
    .resetb_i         (resetb),
    .en_reg_state_i   (en_reg),
    .state_i          (state_in),
    .en_xor_key_end_i (en_xor),
    .key_i            (key),
    .en_cipher_i      (en_cipher),
    .en_tag_i         (en_tag),
`ifdef STATE_REG_SCRUB_EN
    .scrub_i          (scrub),
`endif
    .state_o          (state_out),
    .cipher_o         (cipher),
    .cipher_valid_o   (cipher_valid),
    .cipher_ready_i   (cipher_ready),
    .tag_o            (tag),
    .tag_valid_o      (tag_valid),
    .tag_ready_i      (tag_ready),
    .stall_o          (stall),
    .overflow_o       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [319:0] pack5(input logic [63:0] a, b, c, d, e);
    return {a, b, c, d, e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    en_reg = 0; en_xor = 0; en_cipher = 0; en_tag = 0; scrub = 0;
  endtask

  task automatic test_reset();
    resetb = 0; clear_ctrl(); cipher_ready = 0; tag_ready = 0;
    state_in = '0; key = '0;
    #2;
    n_checks++; if (state_out !== 320'd0) begin n_fail++; $display("FAIL reset_state got %h exp 0", state_out); end
    n_checks++; if (cipher_valid !== 1'b0 || tag_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valids got %b%b exp 00", cipher_valid, tag_valid); end
    n_checks++; if (overflow !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL reset_flags got ovf=%b stall=%b exp 0 0", overflow, stall); end
    n_checks++; if (cipher !== 128'd0 || tag !== 128'd0) begin n_fail++; $display("FAIL reset_bufs got %h %h exp 0 0", cipher, tag); end
    #10 resetb = 1;
  endtask

  task automatic test_key_xor();
    state_in = pack5(64'h1, 64'h2, 64'h3, 64'h4, 64'h5);
    key = {16{8'hA5}};
    en_reg = 1; en_xor = 1;
    step();
    clear_ctrl();
    n_checks++; if (state_out[319:128] !== {64'h1, 64'h2, 64'h3}) begin n_fail++; $display("FAIL xor_s012 got %h exp 000..1/2/3", state_out[319:128]); end
    n_checks++; if (state_out[127:64] !== 64'hA5A5A5A5A5A5A5A1) begin n_fail++; $display("FAIL xor_s3 got %h exp a5a5a5a5a5a5a5a1", state_out[127:64]); end
    n_checks++; if (state_out[63:0] !== 64'hA5A5A5A5A5A5A5A0) begin n_fail++; $display("FAIL xor_s4 got %h exp a5a5a5a5a5a5a5a0", state_out[63:0]); end
    // key XOR request without capture must not touch S
    state_in = pack5(64'h99, 64'h99, 64'h99, 64'h99, 64'h99);
    en_xor = 1;
    step();
    clear_ctrl();
    n_checks++; if (state_out !== pack5(64'h1, 64'h2, 64'h3, 64'hA5A5A5A5A5A5A5A1, 64'hA5A5A5A5A5A5A5A0)) begin n_fail++; $display("FAIL xor_no_cap got %h exp held", state_out); end
    // plain capture, no key
    state_in = pack5(64'h9, 64'h8, 64'h7, 64'h6, 64'h5);
    en_reg = 1;
    step();
    clear_ctrl();
    n_checks++; if (state_out !== pack5(64'h9, 64'h8, 64'h7, 64'h6, 64'h5)) begin n_fail++; $display("FAIL plain_cap got %h exp 9/8/7/6/5", state_out); end
    n_checks++; if (cipher_valid !== 1'b0 || tag_valid !== 1'b0) begin n_fail++; $display("FAIL no_load_valids got %b%b exp 00", cipher_valid, tag_valid); end
  endtask

  task automatic test_cipher_handshake();
    state_in = pack5(64'hDEAD, 64'hBEEF, 64'h0, 64'h0, 64'h0);
    en_reg = 1; en_cipher = 1; cipher_ready = 0;
    step();
    clear_ctrl();
    n_checks++; if (cipher !== {64'hDEAD, 64'hBEEF}) begin n_fail++; $display("FAIL cipher_data got %h exp dead/beef", cipher); end
    n_checks++; if (cipher_valid !== 1'b1) begin n_fail++; $display("FAIL cipher_valid got %b exp 1", cipher_valid); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_full got %b exp 1", stall); end
    cipher_ready = 1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b exp 0", stall); end
    step();
    cipher_ready = 0;
    n_checks++; if (cipher_valid !== 1'b0) begin n_fail++; $display("FAIL cipher_drain got %b exp 0", cipher_valid); end
    cipher_ready = 1;
    step();
    cipher_ready = 0;
    n_checks++; if (cipher_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL ready_empty got v=%b ovf=%b exp 0 0", cipher_valid, overflow); end
  endtask

  task automatic test_load_and_ready();
    state_in = pack5(64'h11, 64'h22, 64'h0, 64'h0, 64'h0);
    en_reg = 1; en_cipher = 1; cipher_ready = 0;
    step();
    state_in = pack5(64'h33, 64'h44, 64'h0, 64'h0, 64'h0);
    cipher_ready = 1;
    step();
    clear_ctrl(); cipher_ready = 0;
    n_checks++; if (cipher_valid !== 1'b1) begin n_fail++; $display("FAIL lr_valid got %b exp 1", cipher_valid); end
    n_checks++; if (cipher !== {64'h33, 64'h44}) begin n_fail++; $display("FAIL lr_data got %h exp 33/44", cipher); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL lr_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_overflow();
    state_in = pack5(64'h77, 64'h88, 64'h0, 64'h0, 64'h0);
    en_reg = 1; en_cipher = 1; cipher_ready = 0;
    step();
    clear_ctrl();
    n_checks++; if (cipher[127:64] !== 64'h77) begin n_fail++; $display("FAIL ovf_data got %h exp 77", cipher[127:64]); end
    n_checks++; if (overflow !== 1'b1 || cipher_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_set got ovf=%b v=%b exp 1 1", overflow, cipher_valid); end
    step(); step(); step();
    cipher_ready = 1;
    step();
    cipher_ready = 0;
    n_checks++; if (overflow !== 1'b1 || cipher_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky got ovf=%b v=%b exp 1 0", overflow, cipher_valid); end
  endtask

  task automatic test_tag();
    state_in = pack5(64'h0, 64'h0, 64'h0, {8{8'hF0}}, {8{8'hF0}});
    key = {16{8'h0F}};
    en_reg = 1; en_xor = 1; en_tag = 1; tag_ready = 0;
    step();
    clear_ctrl();
    n_checks++; if (tag !== {128{1'b1}}) begin n_fail++; $display("FAIL tag_data got %h exp all ones", tag); end
    n_checks++; if (tag_valid !== 1'b1 || cipher_valid !== 1'b0) begin n_fail++; $display("FAIL tag_valid got t=%b c=%b exp 1 0", tag_valid, cipher_valid); end
    n_checks++; if (state_out[127:0] !== {128{1'b1}}) begin n_fail++; $display("FAIL tag_state got %h exp all ones", state_out[127:0]); end
    tag_ready = 1;
    step();
    tag_ready = 0;
    n_checks++; if (tag_valid !== 1'b0) begin n_fail++; $display("FAIL tag_drain got %b exp 0", tag_valid); end
  endtask

  task automatic test_both_buffers();
    state_in = pack5(64'h1, 64'h2, 64'h3, 64'h4, 64'h5);
    key = '0;
    en_reg = 1; en_cipher = 1; en_tag = 1;
    step();
    clear_ctrl();
    n_checks++; if (cipher_valid !== 1'b1 || tag_valid !== 1'b1) begin n_fail++; $display("FAIL both_valid got %b%b exp 11", cipher_valid, tag_valid); end
    n_checks++; if (cipher !== {64'h1, 64'h2} || tag !== {64'h4, 64'h5}) begin n_fail++; $display("FAIL both_data got %h %h exp 1/2 4/5", cipher, tag); end
  endtask

`ifdef STATE_REG_SCRUB_EN
  task automatic test_scrub();
    state_in = pack5(64'hAA, 64'hBB, 64'hCC, 64'hDD, 64'hEE);
    en_reg = 1; en_cipher = 1; en_tag = 1; scrub = 1;
    step();
    clear_ctrl();
    n_checks++; if (state_out !== 320'd0) begin n_fail++; $display("FAIL scrub_state got %h exp 0", state_out); end
    n_checks++; if (cipher_valid !== 1'b0 || tag_valid !== 1'b0) begin n_fail++; $display("FAIL scrub_valids got %b%b exp 00", cipher_valid, tag_valid); end
    n_checks++; if (cipher !== 128'd0 || tag !== 128'd0) begin n_fail++; $display("FAIL scrub_bufs got %h %h exp 0 0", cipher, tag); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL scrub_ovf got %b exp 1", overflow); end
  endtask
`endif

  task automatic test_reset_mid();
    state_in = pack5(64'h1, 64'h2, 64'h3, 64'h4, 64'h5);
    en_reg = 1; en_cipher = 1; en_tag = 1;
    step();
    clear_ctrl();
    #2 resetb = 0;
    #1;
    n_checks++; if (state_out !== 320'd0) begin n_fail++; $display("FAIL mid_reset_state got %h exp 0", state_out); end
    n_checks++; if (cipher_valid !== 1'b0 || tag_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags got c=%b t=%b ovf=%b exp 0 0 0", cipher_valid, tag_valid, overflow); end
    #2 resetb = 1;
    step();
    n_checks++; if (state_out !== 320'd0 || cipher_valid !== 1'b0 || tag_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset got s=%h c=%b t=%b exp 0", state_out, cipher_valid, tag_valid); end
  endtask

  initial begin
    test_reset();
    test_key_xor();
    test_cipher_handshake();
    test_load_and_ready();
    test_overflow();
    test_tag();
    test_both_buffers();
`ifdef STATE_REG_SCRUB_EN
    test_scrub();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/state_register_ctrl.md
Name: state_register_ctrl

Overview:
- Owns the 320-bit ASCON internal state S, held as type_state (5 x 64-bit words S0..S4).
- Captures each permutation round result and feeds it back as the loop-back source for the state input selector.
- Applies the key XOR at the end of initialisation and finalisation.
- Holds ciphertext and tag in two output buffers, each drained through a valid/ready handshake.

Parameters:
- KEY_W, 128, key and tag width in bits.
- RATE_W, 128, data block width (S0||S1).

Ports:
- clock_i  input  1  system clock, rising edge
- resetb_i  input  1  asynchronous active-low reset
- en_reg_state_i  input  1  capture state_i into S this cycle
- state_i  input  320 (type_state)  permutation output
- en_xor_key_end_i  input  1  XOR key into S3||S4 on capture
- key_i  input  KEY_W  key K
- en_cipher_i  input  1  latch S0||S1 of state_i into cipher buffer on capture
- en_tag_i  input  1  latch post-XOR S3||S4 into tag buffer on capture
- state_o  output  320 (type_state)  registered S, to selector loop-back input
- cipher_o  output  RATE_W  buffered ciphertext block
- cipher_valid_o  output  1  cipher buffer full
- cipher_ready_i  input  1  downstream accepts cipher
- tag_o  output  KEY_W  buffered tag
- tag_valid_o  output  1  tag buffer full
- tag_ready_i  input  1  downstream accepts tag
- stall_o  output  1  cipher_valid_o & ~cipher_ready_i (combinational)
- overflow_o  output  1  sticky: a buffered value was overwritten before acceptance

Behaviour:
- Reset (resetb_i=0, asynchronous): S=0, cipher_o=0, tag_o=0, both valids=0, overflow_o=0. Reset mid-operation drops any buffered data and has no further effect.
- State capture, latency 1: if en_reg_state_i=1, then S <= state_i at the next edge. Otherwise S holds.
- Key XOR applies only when en_xor_key_end_i=1 during a capture:
  - S3 <= state_i.S3 ^ key_i[127:64]
  - S4 <= state_i.S4 ^ key_i[63:0]
  - S0..S2 are taken unmodified.
  - en_xor_key_end_i without en_reg_state_i is ignored.
- Cipher buffer:
  - Loads only when en_reg_state_i & en_cipher_i: cipher_o <= {state_i.S0, state_i.S1}, the pre-key-XOR value.
  - Two-state FSM: EMPTY -> FULL on load. FULL -> EMPTY on cipher_ready_i with no load.
  - FULL with load and ready in the same cycle: stays FULL with the new data; this is not an overflow.
  - FULL with load and no ready: new data overwrites the buffer, stays FULL, and overflow_o is set.
  - Ready while EMPTY is ignored.
- Tag buffer:
  - Same FSM rules as the cipher buffer, using en_tag_i and tag_ready_i.
  - Loaded value: tag_o <= {S3', S4'}, where S3'/S4' are the post-XOR values written into S that cycle.
- Flags:
  - cipher_valid_o and tag_valid_o are the FSM state bits (registered).
  - overflow_o clears only on reset.
  - stall_o is combinational. The sequencer must not assert en_cipher_i while stall_o=1.
- en_cipher_i and en_tag_i asserted together in one capture load both buffers in the same cycle.
- state_o is always a register output, with no bypass from state_i.

Optional Feature:
- Macro: STATE_REG_SCRUB_EN.
- With it defined:
  - Adds input port scrub_i (1 bit).
  - scrub_i=1 synchronously zeroes S, cipher_o and tag_o, and clears both valids at the next edge. overflow_o is kept.
  - scrub_i has priority over en_reg_state_i and over any load in the same cycle.
- Without it: no scrub_i port; state and buffers are cleared only by reset.

Test Plan:
- Reset check: resetb_i=0 pulse mid-run -> state_o=0, cipher_valid_o=0, tag_valid_o=0, overflow_o=0 immediately, without waiting for a clock edge.
- Capture with key XOR: state_i words = 64'h1..64'h5, key_i=128'hA5A5...A5, en_reg_state_i=1, en_xor_key_end_i=1.
  - Next cycle: S0..S2 = 1,2,3; S3 = 4^A5A5A5A5A5A5A5A5; S4 = 5^A5A5A5A5A5A5A5A5.
- Cipher handshake: capture with en_cipher_i=1, state_i.S0=64'hDEAD, S1=64'hBEEF, cipher_ready_i=0.
  - Result: cipher_o={DEAD,BEEF}, cipher_valid_o=1, stall_o=1.
  - Raising cipher_ready_i for one cycle drops cipher_valid_o to 0.
- Simultaneous load and ready: buffer FULL, new capture with en_cipher_i=1 and cipher_ready_i=1 -> valid stays 1, new data present, overflow_o=0.
- Overflow: buffer FULL, cipher_ready_i=0, second load with S0=64'h77 -> cipher_o[127:64]=64'h77, overflow_o=1 and stays 1 afterwards.
- Tag path: en_tag_i=1 and en_xor_key_end_i=1 with key_i=128'h0F..0F, S3=S4=64'hF0..F0 -> tag_o=128'hFF..FF, tag_valid_o=1. With the macro defined, scrub_i then clears tag_valid_o and state_o.
